sabr_div_90s_12ns_seq: RTL

- Iterative restoring divider; the inverse companion to the SABR pipelined signed×unsigned multiplier.
- Divides a signed DIVIDEND_WIDTH-bit value by an unsigned DIVISOR_WIDTH-bit value, one quotient bit per enabled clock.
- Returns a saturated signed quotient and a signed remainder.
- Used in SABR path normalisation where a product must be scaled back down; valid/ready handshake on both sides, gated by ce like the rest of the datapath.

---
 rtl/sabr_div_90s_12ns_seq_if.sv | 28 ++
 rtl/sabr_div_90s_12ns_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sabr_div_90s_12ns_seq_if.sv
// Operand/result handshake bundle for the SABR sequential divider.
// The master side supplies operands and accepts results; the divider is the slave.
interface sabr_div_90s_12ns_seq_if #(
  parameter int DIVIDEND_WIDTH = 90,
  parameter int DIVISOR_WIDTH  = 12,
  parameter int QUOT_WIDTH     = 80
);
  logic signed [DIVIDEND_WIDTH-1:0] din0;
  logic        [DIVISOR_WIDTH-1:0]  din1;
  logic                             in_valid;
  logic                             in_ready;
  logic signed [QUOT_WIDTH-1:0]     dout;
  logic signed [DIVISOR_WIDTH:0]    rem;
  logic                             div_by_zero;
  logic                             overflow;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    output din0, din1, in_valid, out_ready,
    input  in_ready, dout, rem, div_by_zero, overflow, out_valid
  );

  modport slave (
    input  din0, din1, in_valid, out_ready,
    output in_ready, dout, rem, div_by_zero, overflow, out_valid
  );
endinterface

// File: rtl/sabr_div_90s_12ns_seq.sv
// Iterative restoring divider: signed dividend / unsigned divisor, one quotient
// bit per enabled clock, saturated signed quotient and dividend-signed remainder.
module sabr_div_90s_12ns_seq #(
  parameter int DIVIDEND_WIDTH = 90,
  parameter int DIVISOR_WIDTH  = 12,
  parameter int QUOT_WIDTH     = 80
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  sabr_div_90s_12ns_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);
  localparam logic signed [QUOT_WIDTH-1:0] Q_MAX = {1'b0, {(QUOT_WIDTH-1){1'b1}}};
  localparam logic signed [QUOT_WIDTH-1:0] Q_MIN = {1'b1, {(QUOT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic                        neg;
  logic                        dz;
  logic [DIVIDEND_WIDTH-1:0]   dvd;
  logic [DIVISOR_WIDTH-1:0]    dsr;
  logic [DIVISOR_WIDTH:0]      part;
  logic [DIVIDEND_WIDTH-1:0]   abs_din0;
  logic [DIVISOR_WIDTH:0]      part_sh;
  logic                        q_bit;

  // Magnitude limit depends on sign: the negative range reaches one further.
  function automatic logic sat_hit(input logic [DIVIDEND_WIDTH-1:0] mag,
                                   input logic is_neg);
    logic [DIVIDEND_WIDTH-1:0] lim;
    lim = DIVIDEND_WIDTH'(1) << (QUOT_WIDTH - 1);
    if (!is_neg) lim = lim - DIVIDEND_WIDTH'(1);
    return mag > lim;
  endfunction

  function automatic logic signed [QUOT_WIDTH-1:0] sat_quot(
      input logic [DIVIDEND_WIDTH-1:0] mag, input logic is_neg);
    logic signed [QUOT_WIDTH-1:0] m;
    m = signed'(mag[QUOT_WIDTH-1:0]);
    if (sat_hit(mag, is_neg)) return is_neg ? Q_MIN : Q_MAX;
    return is_neg ? -m : m;
  endfunction

  assign bus.in_ready = (state == IDLE);

  always_comb begin
    abs_din0 = bus.din0[DIVIDEND_WIDTH-1] ? ($unsigned(~bus.din0) + DIVIDEND_WIDTH'(1))
                                          : $unsigned(bus.din0);
    part_sh  = {part[DIVISOR_WIDTH-1:0], dvd[DIVIDEND_WIDTH-1]};
    q_bit    = (part_sh >= {1'b0, dsr});
  end

  // Control and visible outputs: cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      neg             <= 1'b0;
      dz              <= 1'b0;
      bus.dout        <= '0;
      bus.rem         <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.out_valid   <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            neg             <= bus.din0[DIVIDEND_WIDTH-1];
            dz              <= (bus.din1 == '0);
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            cnt             <= CNT_W'(DIVIDEND_WIDTH);
            // A zero divisor skips the iterations but still takes the one FIX edge.
            state           <= (bus.din1 == '0) ? FIX : ITER;
          end
        end
        ITER: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            bus.dout        <= neg ? Q_MIN : Q_MAX;
            bus.rem         <= '0;
            bus.div_by_zero <= 1'b1;
            bus.overflow    <= 1'b0;
          end else begin
            bus.dout        <= sat_quot(dvd, neg);
            bus.rem         <= neg ? -part : part;
            bus.overflow    <= sat_hit(dvd, neg);
          end
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: dvd shifts dividend bits out of the top and quotient bits in at the bottom.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (state == IDLE && bus.in_valid) begin
        dvd  <= abs_din0;
        dsr  <= bus.din1;
        part <= '0;
      end else if (state == ITER) begin
        part <= q_bit ? (part_sh - {1'b0, dsr}) : part_sh;
        dvd  <= {dvd[DIVIDEND_WIDTH-2:0], q_bit};
      end
    end
  end

endmodule
